// File: rtl/fir_out_requant_pkg.sv
// Shared widths, rounding shift and saturation limits for the FIR output requantiser.
// The limit helpers let any instance derive its own clip bounds from OUT_BITS.
package fir_out_requant_pkg;

  localparam int DEF_IN_BITS  = 32;
  localparam int DEF_OUT_BITS = 16;
  localparam int DEF_SHIFT    = 11;
  localparam int DEF_DEPTH    = 16;

  function automatic longint sat_max(input int bits);
    return (longint'(1) <<< (bits - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_OUT_BITS);
  localparam longint SAT_MIN = sat_min(DEF_OUT_BITS);

endpackage

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO.
// A write to a full FIFO is accepted only when a read frees the head slot at the same edge.
module sync_fwft_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign valid = (level != '0);
  assign full  = (level == (AW + 1)'(DEPTH));
  assign pop   = rd_en & valid;
  assign push  = wr_en & (~full | pop);
  assign drop  = wr_en & full & ~pop;

  // Forcing zero when empty keeps the output defined straight out of reset.
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// Captures one FIR result per rising edge of its valid level, rounds and clips it
// to OUT_BITS, and buffers the samples in a FWFT FIFO with sticky drop/clip flags.
module fir_out_requant
  import fir_out_requant_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int SHIFT    = DEF_SHIFT,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_in_vld,
  input  logic signed [IN_BITS-1:0]  data_in,
  output logic signed [OUT_BITS-1:0] data_out,
  output logic                       data_out_vld,
  input  logic                       data_out_rdy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow,
  output logic                       sat_flag,
  input  logic                       clr_flags
);

  localparam int RW = IN_BITS + 1;
  localparam logic signed [RW-1:0] R_MAX = RW'(sat_max(OUT_BITS));
  localparam logic signed [RW-1:0] R_MIN = RW'(sat_min(OUT_BITS));
  localparam logic signed [RW-1:0] HALF  = RW'(longint'(1) <<< (SHIFT - 1));

  logic                       vld_d1;
  logic                       vld_d2;
  logic                       cap;
  logic signed [IN_BITS-1:0]  s1;
  logic                       s1_vld;
  logic signed [RW-1:0]       sum;
  logic signed [RW-1:0]       r;
  logic signed [OUT_BITS-1:0] sat_val;
  logic                       sat_hit;
  logic                       drop;

  // The valid is a level that may be held, so only its first high sample starts a capture.
  assign cap = vld_d1 & ~vld_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_d1 <= 1'b0;
      vld_d2 <= 1'b0;
      s1     <= '0;
      s1_vld <= 1'b0;
    end else begin
      vld_d1 <= data_in_vld;
      vld_d2 <= vld_d1;
      s1_vld <= cap;
      if (cap) begin
        s1 <= data_in;
      end
    end
  end

  // Stage 2 is combinational into the FIFO write port; s1_vld doubles as its valid.
  always_comb begin
    sum     = RW'(s1) + HALF;
    r       = sum >>> SHIFT;
    sat_hit = 1'b0;
    sat_val = r[OUT_BITS-1:0];
    if (r > R_MAX) begin
      sat_val = R_MAX[OUT_BITS-1:0];
      sat_hit = 1'b1;
    end else if (r < R_MIN) begin
      sat_val = R_MIN[OUT_BITS-1:0];
      sat_hit = 1'b1;
    end
  end

  // A set event wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (s1_vld && sat_hit) begin
        sat_flag <= 1'b1;
      end else if (clr_flags) begin
        sat_flag <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
    end
  end

  sync_fwft_fifo #(
    .WIDTH (OUT_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s1_vld),
    .wr_data (sat_val),
    .rd_en   (data_out_rdy),
    .rd_data (data_out),
    .valid   (data_out_vld),
    .level   (fifo_level),
    .drop    (drop)
  );

endmodule
